// File: rtl/latsnq_pipe_bank_pkg.sv
// Shared defaults for the settable, scannable register pipeline bank.
package latsnq_pipe_bank_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;
endpackage

// File: rtl/latsnq_pipe_bank_if.sv
// Data/control bundle of the pipeline bank; clock and reset stay separate ports.
interface latsnq_pipe_bank_if
    import latsnq_pipe_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             E;
    logic [WIDTH-1:0] D;
    logic             DV;
    logic             SETN;
    logic             SE;
    logic             SI;
    logic [WIDTH-1:0] Q;
    logic             QV;
    logic             SO;

    modport master (output E, D, DV, SETN, SE, SI, input Q, QV, SO);
    modport slave  (input E, D, DV, SETN, SE, SI, output Q, QV, SO);
endinterface

// File: rtl/latsnq_pipe_stage.sv
// One WIDTH-bit stage: data + valid, with scan > preset > advance > hold.
module latsnq_pipe_stage
    import latsnq_pipe_bank_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
    parameter bit               SET_VALID = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic             set_n,
    input  logic             adv,
    input  logic [WIDTH-1:0] d,
    input  logic             dv,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             qv
);
    logic [WIDTH-1:0] scan_next;

    // Scan enters at bit 0 and moves toward the MSB, which feeds the next stage.
    generate
        if (WIDTH == 1) begin : g_w1
            assign scan_next = si;
        end else begin : g_wn
            assign scan_next = {q[WIDTH-2:0], si};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q  <= '0;
            qv <= 1'b0;
        end else if (scan_en) begin
            q  <= scan_next;
        end else if (!set_n) begin
            q  <= SET_VALUE;
            qv <= SET_VALID;
        end else if (adv) begin
            q  <= d;
            qv <= dv;
        end
    end
endmodule

// File: rtl/latsnq_pipe_bank.sv
// WIDTH x DEPTH settable, scannable delay bank; stitches stages into one pipe and one chain.
module latsnq_pipe_bank
    import latsnq_pipe_bank_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}},
    parameter bit               SET_VALID = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RN,
    latsnq_pipe_bank_if.slave    bus
);
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] d_in;
    logic [DEPTH-1:0]            v_in;
    logic [DEPTH-1:0]            s_in;

    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            if (s == 0) begin : g_head
                assign d_in[s] = bus.D;
                assign v_in[s] = bus.DV;
                assign s_in[s] = bus.SI;
            end else begin : g_body
                assign d_in[s] = data[s-1];
                assign v_in[s] = vld[s-1];
                assign s_in[s] = data[s-1][WIDTH-1];
            end

            latsnq_pipe_stage #(
                .WIDTH    (WIDTH),
                .SET_VALUE(SET_VALUE),
                .SET_VALID(SET_VALID)
            ) u_stage (
                .clk    (CLK),
                .rst_n  (RN),
                .scan_en(bus.SE),
                .set_n  (bus.SETN),
                .adv    (bus.E),
                .d      (d_in[s]),
                .dv     (v_in[s]),
                .si     (s_in[s]),
                .q      (data[s]),
                .qv     (vld[s])
            );
        end
    endgenerate

    assign bus.Q  = data[DEPTH-1];
    assign bus.QV = vld[DEPTH-1];
    assign bus.SO = data[DEPTH-1][WIDTH-1];
endmodule
